// File: rtl/period_meter_pkg.sv
// Shared types for the period meter: FSM state encoding.
// Latency: n/a (types only).
// Backpressure: n/a.
package period_meter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2
    } state_t;

endpackage

// File: rtl/period_meter_if.sv
// Result channel of the period meter: period/overflow qualified by valid, accepted by out_ready.
// Latency: n/a (wiring only).
// Backpressure: producer holds period/overflow stable while valid is high and out_ready is low.
interface period_meter_if #(
    parameter int N = 8
);
    logic [N-1:0] period;
    logic         overflow;
    logic         valid;
    logic         out_ready;

    modport master (
        output period,
        output overflow,
        output valid,
        input  out_ready
    );

    modport slave (
        input  period,
        input  overflow,
        input  valid,
        output out_ready
    );
endinterface

// File: rtl/period_meter_edge_rise.sv
// Rising-edge detector for a level input already synchronous to clk.
// Latency: combinational edge output, one register of history.
// Backpressure: none; the detector runs every cycle regardless of downstream state.
module edge_rise (
    input  logic clk,
    input  logic rst_n,
    input  logic event_in,
    output logic rise
);
    logic ev_q;

    // Keep last cycle's level so a held-high input never looks like a new edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ev_q <= 1'b0;
        end else begin
            ev_q <= event_in;
        end
    end

    assign rise = event_in & ~ev_q;
endmodule

// File: rtl/period_meter.sv
// Measures clock cycles between consecutive rising edges of event_in, saturating at 2^N-1.
// Latency: result registered on the clock edge that sees the closing edge; valid high the next cycle.
// Backpressure: a result arriving while valid is held and out_ready is low is discarded and flagged in sticky dropped.
module period_meter
    import period_meter_pkg::*;
#(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic           event_in,
    period_meter_if.master res,
    output logic           dropped,
    output logic           busy
);
    localparam logic [1:0]   S_IDLE    = IDLE;
    localparam logic [1:0]   S_ARM     = ARM;
    localparam logic [1:0]   S_MEASURE = MEASURE;
    localparam logic [N-1:0] CNT_MAX   = {N{1'b1}};
    localparam logic [N-1:0] CNT_ONE   = {{(N-1){1'b0}}, 1'b1};

    logic         rise;
    logic [1:0]   state;
    logic [1:0]   state_nxt;
    logic [N-1:0] cnt;
    logic         sat;
    logic         cap;

    edge_rise u_edge (
        .clk      (clk),
        .rst_n    (rst_n),
        .event_in (event_in),
        .rise     (rise)
    );

    // Next state: disable wins over everything, the first edge after arming starts measuring.
    always_comb begin
        state_nxt = state;
        if (!en) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:    state_nxt = S_ARM;
                S_ARM:     state_nxt = rise ? S_MEASURE : S_ARM;
                S_MEASURE: state_nxt = S_MEASURE;
                default:   state_nxt = S_IDLE;
            endcase
        end
    end

    // An edge while measuring closes the running period.
    assign cap = en && (state == S_MEASURE) && rise;

    // State register; busy is registered alongside so it tracks MEASURE exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt == S_MEASURE);
        end
    end

    // Period counter: each edge restarts at 1, otherwise count up and stick at max with sat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            sat <= 1'b0;
        end else if (!en || (state == S_IDLE)) begin
            cnt <= '0;
            sat <= 1'b0;
        end else if (rise) begin
            cnt <= CNT_ONE;
            sat <= 1'b0;
        end else if (state == S_MEASURE) begin
            if (cnt == CNT_MAX) begin
                sat <= 1'b1;
            end else begin
                cnt <= cnt + CNT_ONE;
            end
        end else begin
            cnt <= '0;
            sat <= 1'b0;
        end
    end

    // Output register: load when the slot is free or being drained this cycle, else drop and flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res.period   <= '0;
            res.overflow <= 1'b0;
            res.valid    <= 1'b0;
            dropped      <= 1'b0;
        end else if (cap) begin
            if (!res.valid || res.out_ready) begin
                res.period   <= cnt;
                res.overflow <= sat;
                res.valid    <= 1'b1;
            end else begin
                dropped <= 1'b1;
            end
        end else if (res.valid && res.out_ready) begin
            res.valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_period_meter.sv
// Self-checking bench for period_meter: directed scenarios plus randomized traffic against a time-stamp model.
// Latency: outputs sampled 1 time unit after each rising clock edge.
// Backpressure: out_ready driven per scenario, randomized in the soak test.
module tb_period_meter;
    localparam int N    = 8;
    localparam int MAXV = (1 << N) - 1;

    logic clk      = 1'b0;
    logic rst_n    = 1'b0;
    logic en       = 1'b0;
    logic event_in = 1'b0;
    logic dropped;
    logic busy;

    period_meter_if #(.N(N)) rif ();

    period_meter #(.N(N)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .event_in (event_in),
        .res      (rif),
        .dropped  (dropped),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Reference model: remembers the cycle number of the last counted edge.
    int           t;
    int           t0;
    bit           started;
    bit           m_en_q;
    bit           m_ev_q;
    bit           m_valid;
    bit           m_ovf;
    bit           m_drop;
    bit           m_busy;
    logic [N-1:0] m_period;

    int n_pass  = 0;
    int n_total = 0;
    int n_print = 0;

    logic [N+3:0] obs;
    assign obs = {rif.valid, busy, dropped, rif.overflow, rif.period};

    function automatic logic [N+3:0] exp_vec();
        return {m_valid, m_busy, m_drop, m_ovf, m_period};
    endfunction

    task automatic model_reset();
        t        = 0;
        t0       = 0;
        started  = 1'b0;
        m_en_q   = 1'b0;
        m_ev_q   = 1'b0;
        m_valid  = 1'b0;
        m_ovf    = 1'b0;
        m_drop   = 1'b0;
        m_busy   = 1'b0;
        m_period = '0;
    endtask

    // One clock: apply inputs, advance the model by the same edge, sample after the edge.
    task automatic cyc(input bit e, input bit ev, input bit r);
        bit rise;
        bit act;
        int d;
        en            = e;
        event_in      = ev;
        rif.out_ready = r;
        rise = ev && !m_ev_q;
        act  = e && m_en_q;
        if (act && rise) begin
            if (started) begin
                d = t - t0;
                if (!m_valid || r) begin
                    m_period = (d > MAXV) ? N'(MAXV) : N'(d);
                    m_ovf    = (d > MAXV);
                    m_valid  = 1'b1;
                end else begin
                    m_drop = 1'b1;
                end
            end
            t0      = t;
            started = 1'b1;
        end else if (m_valid && r) begin
            m_valid = 1'b0;
        end
        if (!act) started = 1'b0;
        m_busy = act && started;
        m_ev_q = ev;
        m_en_q = e;
        t      = t + 1;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        en            = 1'b0;
        event_in      = 1'b0;
        rif.out_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_total++;
        if (obs !== '0) $display("FAIL reset_values got=%h want=0", obs);
        else n_pass++;
        cyc(1, 0, 1);
        cyc(1, 1, 1);
        repeat (3) cyc(1, 0, 1);
        n_total++;
        if (busy !== 1'b1) $display("FAIL reset_busy_before got=%b want=1", busy);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_total++;
        if (obs !== '0) $display("FAIL reset_async got=%h want=0", obs);
        else n_pass++;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(1, 0, 1);
        cyc(1, 1, 1);
        n_total++;
        if (rif.valid !== 1'b0 || busy !== 1'b1) $display("FAIL reset_first_edge valid=%b busy=%b want valid=0 busy=1", rif.valid, busy);
        else n_pass++;
        repeat (9) cyc(1, 0, 1);
        cyc(1, 1, 1);
        n_total++;
        if ({rif.valid, rif.overflow, rif.period} !== {1'b1, 1'b0, 8'd10})
            $display("FAIL reset_period10 got v=%b o=%b p=%0d want v=1 o=0 p=10", rif.valid, rif.overflow, rif.period);
        else n_pass++;
        n_total++;
        if (obs !== exp_vec()) $display("FAIL reset_model got=%h want=%h", obs, exp_vec());
        else n_pass++;
    endtask

    task automatic test_periodic();
        int g;
        do_reset();
        cyc(1, 0, 1);
        for (int k = 0; k < 6; k++) begin
            cyc(1, 1, 1);
            n_total++;
            if (k == 0) begin
                if (rif.valid !== 1'b0) $display("FAIL periodic_arm valid=%b want=0", rif.valid);
                else n_pass++;
            end else begin
                if ({rif.valid, rif.overflow, rif.period} !== {1'b1, 1'b0, 8'd5})
                    $display("FAIL periodic_5 k=%0d got v=%b o=%b p=%0d want v=1 o=0 p=5", k, rif.valid, rif.overflow, rif.period);
                else n_pass++;
            end
            repeat (4) begin
                cyc(1, 0, 1);
                n_total++;
                if (obs !== exp_vec()) $display("FAIL periodic_gap got=%h want=%h", obs, exp_vec());
                else n_pass++;
            end
        end
        for (int k = 0; k < 8; k++) begin
            g = $urandom_range(2, 40);
            cyc(1, 1, 1);
            n_total++;
            if (obs !== exp_vec()) $display("FAIL periodic_rand gap=%0d got=%h want=%h", g, obs, exp_vec());
            else n_pass++;
            repeat (g - 1) cyc(1, 0, 1);
        end
    endtask

    task automatic test_saturation();
        int           gaps [4] = '{255, 256, 300, 2};
        logic [N-1:0] exp_p[4] = '{8'd255, 8'd255, 8'd255, 8'd2};
        bit           exp_o[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        do_reset();
        cyc(1, 0, 1);
        cyc(1, 1, 1);
        for (int k = 0; k < 4; k++) begin
            repeat (gaps[k] - 1) cyc(1, 0, 1);
            cyc(1, 1, 1);
            n_total++;
            if ({rif.valid, rif.overflow, rif.period} !== {1'b1, exp_o[k], exp_p[k]})
                $display("FAIL saturation gap=%0d got v=%b o=%b p=%0d want v=1 o=%b p=%0d",
                         gaps[k], rif.valid, rif.overflow, rif.period, exp_o[k], exp_p[k]);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        cyc(1, 0, 0);
        for (int k = 0; k < 4; k++) begin
            cyc(1, 1, 0);
            if (k == 1) begin
                n_total++;
                if ({rif.valid, dropped, rif.period} !== {1'b1, 1'b0, 8'd4})
                    $display("FAIL bp_first got v=%b d=%b p=%0d want v=1 d=0 p=4", rif.valid, dropped, rif.period);
                else n_pass++;
            end
            if (k == 2) begin
                n_total++;
                if ({rif.valid, dropped, rif.period} !== {1'b1, 1'b1, 8'd4})
                    $display("FAIL bp_drop got v=%b d=%b p=%0d want v=1 d=1 p=4", rif.valid, dropped, rif.period);
                else n_pass++;
            end
            repeat (3) cyc(1, 0, 0);
        end
        cyc(1, 0, 1);
        n_total++;
        if ({rif.valid, dropped} !== 2'b01) $display("FAIL bp_drain got v=%b d=%b want v=0 d=1", rif.valid, dropped);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        cyc(1, 0, 0);
        cyc(1, 1, 0);
        repeat (5) cyc(1, 0, 0);
        cyc(1, 1, 0);
        n_total++;
        if ({rif.valid, rif.period} !== {1'b1, 8'd6}) $display("FAIL b2b_first got v=%b p=%0d want v=1 p=6", rif.valid, rif.period);
        else n_pass++;
        repeat (8) cyc(1, 0, 0);
        cyc(1, 1, 1);
        n_total++;
        if ({rif.valid, dropped, rif.period} !== {1'b1, 1'b0, 8'd9})
            $display("FAIL b2b_load got v=%b d=%b p=%0d want v=1 d=0 p=9", rif.valid, dropped, rif.period);
        else n_pass++;
        cyc(1, 0, 1);
        n_total++;
        if (rif.valid !== 1'b0) $display("FAIL b2b_clear got v=%b want=0", rif.valid);
        else n_pass++;
    endtask

    task automatic test_enable();
        do_reset();
        repeat (3) cyc(0, 1, 0);
        repeat (3) cyc(1, 1, 0);
        n_total++;
        if ({busy, rif.valid} !== 2'b00) $display("FAIL en_level_high got busy=%b v=%b want 0 0", busy, rif.valid);
        else n_pass++;
        cyc(1, 0, 0);
        cyc(1, 1, 0);
        n_total++;
        if ({busy, rif.valid} !== 2'b10) $display("FAIL en_arm got busy=%b v=%b want 1 0", busy, rif.valid);
        else n_pass++;
        repeat (6) cyc(1, 0, 0);
        cyc(1, 1, 0);
        n_total++;
        if ({rif.valid, rif.period} !== {1'b1, 8'd7}) $display("FAIL en_period7 got v=%b p=%0d want v=1 p=7", rif.valid, rif.period);
        else n_pass++;
        repeat (3) cyc(1, 0, 0);
        repeat (3) cyc(0, 0, 0);
        n_total++;
        if ({busy, rif.valid, rif.period} !== {1'b0, 1'b1, 8'd7})
            $display("FAIL en_drop_keep got busy=%b v=%b p=%0d want busy=0 v=1 p=7", busy, rif.valid, rif.period);
        else n_pass++;
        cyc(1, 0, 0);
        cyc(1, 1, 0);
        n_total++;
        if ({busy, rif.valid, dropped, rif.period} !== {1'b1, 1'b1, 1'b0, 8'd7})
            $display("FAIL en_rearm got busy=%b v=%b d=%b p=%0d want 1 1 0 7", busy, rif.valid, dropped, rif.period);
        else n_pass++;
        cyc(1, 0, 1);
        repeat (2) cyc(1, 0, 0);
        cyc(1, 1, 0);
        n_total++;
        if ({rif.valid, dropped, rif.period} !== {1'b1, 1'b0, 8'd4})
            $display("FAIL en_fresh got v=%b d=%b p=%0d want v=1 d=0 p=4", rif.valid, dropped, rif.period);
        else n_pass++;
    endtask

    task automatic test_random();
        bit e;
        bit ev;
        bit r;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            e  = ($urandom_range(0, 63) != 0);
            ev = ($urandom_range(0, 2) == 0);
            r  = ($urandom_range(0, 3) != 0);
            cyc(e, ev, r);
            n_total++;
            if (obs !== exp_vec()) begin
                if (n_print < 20) $display("FAIL random cyc=%0d got=%h want=%h", i, obs, exp_vec());
                n_print++;
            end else begin
                n_pass++;
            end
        end
    endtask

    initial begin
        rif.out_ready = 1'b0;
        model_reset();
        test_reset();
        test_periodic();
        test_saturation();
        test_backpressure();
        test_back_to_back();
        test_enable();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
